ieee_multi_to_fpir_pipe: RTL and testbench
==========================================

# ieee_multi_to_fpir_pipe

Parametrised, two-stage pipelined converter from IEEE-754 binary32, binary16 or bfloat16 to the FPIR internal value format, with a per-transaction format select. It extends the single-format combinational IEEE-to-FPIR decode in three ways: true subnormal normalisation through a leading-zero count, elastic valid/ready handshaking with full-throughput backpressure, and a synchronous flush. It sits at the operand-ingress boundary of the float datapath, ahead of the FPIR arithmetic units.

## Interface
- BW_EXPONENT, 8, FPIR exponent field width; BW_EXPONENT+BW_OVERFLOW must be ≥ 10.
- BW_OVERFLOW, 2, FPIR overflow field width (upper bits of the signed unbiased exponent).
- BW_SIGNIFICAND, 24, FPIR significand field width.
- BW_GUARD, 3, FPIR guard field width; BW_SIGNIFICAND+BW_GUARD must be ≥ 24.
- BW_FPIR (derived) = `BW_FPIR_TYPE + 1 + BW_EXPONENT + BW_SIGNIFICAND + BW_GUARD + BW_OVERFLOW.
- clk  in  1  clock.
- rstp  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of both stages.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  converter accepts the input this cycle.
- in_mode  in  2  00 binary32, 01 binary16 (in_value[15:0]), 10 bfloat16 (in_value[15:0]), 11 reserved.
- in_value  in  32  IEEE bit pattern.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_fpir  out  BW_FPIR  {type, sign, exponent, significand, guard, overflow}.
- out_subnormal  out  1  input was a nonzero subnormal.
- out_bad_mode  out  1  in_mode was 11.

## Operation
- Field split per mode (exponent width / mantissa width / bias): binary32 8/23/127, binary16 5/10/15, bfloat16 8/7/127.
- Classification, evaluated in priority order:
  - mode 11 → NAN with out_bad_mode=1.
  - exponent all-ones and mantissa ≠ 0 → NAN.
  - exponent all-ones and mantissa = 0 → PINF or MINF by sign.
  - exponent 0 and mantissa = 0 → PZERO or MZERO by sign.
  - otherwise NORMAL.
- Sign field is always the IEEE sign bit, including for NaN.
- Normal input: significand = {1, mantissa}; unbiased exponent = e − bias.
- Subnormal input: lz = leading-zero count of the mantissa within its mode width. Significand = mantissa << (lz+1), with the leading one at the MSB. Exponent = 1 − bias − (lz+1). Set out_subnormal.
- The significand is left-justified into {significand, guard} with zero fill. The leading one always lands at the MSB of the significand field.
- {overflow, exponent} is the two's-complement unbiased exponent, sign-extended to BW_OVERFLOW+BW_EXPONENT bits.
- NAN, INF and ZERO types drive zero exponent, significand, guard and overflow fields.
- Stage 1 registers the split fields, the class and lz. Stage 2 registers the shifted and packed result.

## Timing
- Reset: both stage valid bits 0; out_valid=0; out_fpir=0; out_subnormal=0; out_bad_mode=0.
- Latency: exactly 2 cycles from input acceptance to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Ready logic:
  - s2_ready = !s2_valid | out_ready.
  - s1_ready = !s1_valid | s2_ready.
  - in_ready = s1_ready.
- The handshake fires on valid&ready. An input is accepted only when in_valid&in_ready.
- out_fpir and the flags hold stable while out_valid=1 and out_ready=0.
- With out_ready held low, at most 2 transactions are buffered, and in_ready then goes 0. There is no drop and no duplication, and order is preserved.
- clear: next edge zeroes both valid bits. A simultaneous input is discarded. in_ready=1 in the cycle after clear.
- rstp asserted mid-transfer: valid bits drop immediately (asynchronous), and in-flight data is lost.
- in_mode is sampled with in_value at acceptance. A mode change between back-to-back transactions is legal.

## Test plan
- Binary32 0x3F800000 → type NORMAL, sign 0, exponent 0, overflow 0, significand 0x800000, guard 0, out_valid at cycle 2.
- Binary16 0x0001 → NORMAL, out_subnormal=1, {overflow,exponent} = −24 (0x3E8 at 10 bits), significand 0x800000. Binary32 0x00000001 → exponent −149.
- Bfloat16 0xFF80 → MINF with zero fields. Binary16 0x7E00 → NAN. Binary32 0x80000000 → MZERO. in_mode=11 → NAN with out_bad_mode=1.
- Stream 6 mixed-mode inputs with out_ready low for 3 cycles mid-stream → in_ready low after 2 are buffered, all 6 outputs arrive in order and bit-exact.
- Pulse clear with 2 transactions in flight and in_valid=1 → no output from any of them, next accepted input emerges 2 cycles later.
- Assert rstp asynchronously between edges while out_valid=1 → out_valid falls before the next edge, all outputs reset to 0.

Source files
------------

// File: rtl/ieee_multi_to_fpir_pipe_if.sv
// rtl/ieee_multi_to_fpir_pipe_if.sv - ingress/egress handshake bundle for the multi-format IEEE-to-FPIR converter
`ifndef BW_FPIR_TYPE
`define BW_FPIR_TYPE 3
`endif

interface ieee_multi_to_fpir_pipe_if #(
  parameter int BW_FPIR = `BW_FPIR_TYPE + 1 + 8 + 24 + 3 + 2
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_mode;
  logic [31:0]        in_value;
  logic               out_valid;
  logic               out_ready;
  logic [BW_FPIR-1:0] out_fpir;
  logic               out_subnormal;
  logic               out_bad_mode;

  modport master (
    output in_valid, in_mode, in_value, out_ready,
    input  in_ready, out_valid, out_fpir, out_subnormal, out_bad_mode
  );

  modport slave (
    input  in_valid, in_mode, in_value, out_ready,
    output in_ready, out_valid, out_fpir, out_subnormal, out_bad_mode
  );
endinterface

// File: rtl/ieee_multi_to_fpir_pipe.sv
// rtl/ieee_multi_to_fpir_pipe.sv - two-stage binary32/binary16/bfloat16 to FPIR converter with elastic handshake
`ifndef BW_FPIR_TYPE
`define BW_FPIR_TYPE 3
`endif

module ieee_multi_to_fpir_pipe #(
  parameter int BW_EXPONENT    = 8,
  parameter int BW_OVERFLOW    = 2,
  parameter int BW_SIGNIFICAND = 24,
  parameter int BW_GUARD       = 3
) (
  input logic clk,
  input logic rstp,
  input logic clear,
  ieee_multi_to_fpir_pipe_if.slave bus
);

  localparam int BW_TYPE = `BW_FPIR_TYPE;
  localparam int BW_FPIR = BW_TYPE + 1 + BW_EXPONENT + BW_SIGNIFICAND + BW_GUARD + BW_OVERFLOW;
  localparam int BW_XE   = BW_EXPONENT + BW_OVERFLOW;
  localparam int BW_SG   = BW_SIGNIFICAND + BW_GUARD;

  localparam logic [BW_TYPE-1:0] T_NORMAL = BW_TYPE'(0);
  localparam logic [BW_TYPE-1:0] T_PZERO  = BW_TYPE'(1);
  localparam logic [BW_TYPE-1:0] T_MZERO  = BW_TYPE'(2);
  localparam logic [BW_TYPE-1:0] T_PINF   = BW_TYPE'(3);
  localparam logic [BW_TYPE-1:0] T_MINF   = BW_TYPE'(4);
  localparam logic [BW_TYPE-1:0] T_NAN    = BW_TYPE'(5);

  logic               in_sign;
  logic [7:0]         in_exp;
  logic [22:0]        in_man;
  logic               in_exp_ones;
  logic [BW_TYPE-1:0] in_type;
  logic               in_bad;
  logic               in_sub;
  logic [4:0]         in_lz;
  logic               lz_found;

  logic               s1_valid;
  logic [BW_TYPE-1:0] s1_type;
  logic               s1_sign;
  logic               s1_bad;
  logic               s1_sub;
  logic               s1_bias16;
  logic [7:0]         s1_exp;
  logic [22:0]        s1_man;
  logic [4:0]         s1_lz;

  logic               s2_valid;
  logic [BW_FPIR-1:0] s2_fpir;
  logic               s2_sub;
  logic               s2_bad;

  logic               s1_ready;
  logic               s2_ready;

  logic signed [31:0] bias;
  logic signed [31:0] exp_int;
  logic [23:0]        sig24;
  logic [BW_XE-1:0]   xe;
  logic [BW_SG-1:0]   sg;
  logic [BW_FPIR-1:0] fpir_next;

  assign s2_ready     = !s2_valid || bus.out_ready;
  assign s1_ready     = !s1_valid || s2_ready;
  assign bus.in_ready = s1_ready;

  // Mantissa is left-aligned into 23 bits so one leading-zero counter serves all modes.
  // The reserved mode splits like binary32 so its sign comes from bit 31.
  always_comb begin
    in_sign     = bus.in_value[31];
    in_exp      = bus.in_value[30:23];
    in_man      = bus.in_value[22:0];
    in_exp_ones = &bus.in_value[30:23];
    case (bus.in_mode)
      2'b01: begin
        in_sign     = bus.in_value[15];
        in_exp      = {3'b000, bus.in_value[14:10]};
        in_man      = {bus.in_value[9:0], 13'b0};
        in_exp_ones = &bus.in_value[14:10];
      end
      2'b10: begin
        in_sign     = bus.in_value[15];
        in_exp      = bus.in_value[14:7];
        in_man      = {bus.in_value[6:0], 16'b0};
        in_exp_ones = &bus.in_value[14:7];
      end
      default: ;
    endcase
  end

  always_comb begin
    in_bad  = (bus.in_mode == 2'b11);
    in_sub  = 1'b0;
    in_type = T_NORMAL;
    if (in_bad) begin
      in_type = T_NAN;
    end else if (in_exp_ones) begin
      in_type = (|in_man) ? T_NAN : (in_sign ? T_MINF : T_PINF);
    end else if (in_exp == 8'd0) begin
      if (|in_man) in_sub = 1'b1;
      else         in_type = in_sign ? T_MZERO : T_PZERO;
    end
  end

  always_comb begin
    in_lz    = 5'd0;
    lz_found = 1'b0;
    for (int i = 22; i >= 0; i--) begin
      if (!lz_found && in_man[i]) begin
        in_lz    = 5'(22 - i);
        lz_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      s1_valid  <= 1'b0;
      s1_type   <= T_NORMAL;
      s1_sign   <= 1'b0;
      s1_bad    <= 1'b0;
      s1_sub    <= 1'b0;
      s1_bias16 <= 1'b0;
      s1_exp    <= 8'd0;
      s1_man    <= 23'd0;
      s1_lz     <= 5'd0;
    end else begin
      if (clear)         s1_valid <= 1'b0;
      else if (s1_ready) s1_valid <= bus.in_valid;
      if (bus.in_valid && s1_ready && !clear) begin
        s1_type   <= in_type;
        s1_sign   <= in_sign;
        s1_bad    <= in_bad;
        s1_sub    <= in_sub;
        s1_bias16 <= (bus.in_mode == 2'b01);
        s1_exp    <= in_exp;
        s1_man    <= in_man;
        s1_lz     <= in_lz;
      end
    end
  end

  // Subnormals: shifting {man,0} by lz puts the first set mantissa bit at the significand MSB.
  always_comb begin
    bias = s1_bias16 ? 32'sd15 : 32'sd127;
    if (s1_sub) begin
      sig24   = {s1_man, 1'b0} << s1_lz;
      exp_int = -bias - int'(s1_lz);
    end else begin
      sig24   = {1'b1, s1_man};
      exp_int = int'({24'd0, s1_exp}) - bias;
    end
    xe = BW_XE'(exp_int);
    sg = BW_SG'(sig24) << (BW_SG - 24);
    if (s1_type == T_NORMAL)
      fpir_next = {s1_type, s1_sign, xe[BW_EXPONENT-1:0], sg, xe[BW_XE-1:BW_EXPONENT]};
    else
      fpir_next = {s1_type, s1_sign, {(BW_FPIR-BW_TYPE-1){1'b0}}};
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      s2_valid <= 1'b0;
      s2_fpir  <= '0;
      s2_sub   <= 1'b0;
      s2_bad   <= 1'b0;
    end else begin
      if (clear)         s2_valid <= 1'b0;
      else if (s2_ready) s2_valid <= s1_valid;
      if (s1_valid && s2_ready && !clear) begin
        s2_fpir <= fpir_next;
        s2_sub  <= s1_sub;
        s2_bad  <= s1_bad;
      end
    end
  end

  assign bus.out_valid     = s2_valid;
  assign bus.out_fpir      = s2_fpir;
  assign bus.out_subnormal = s2_sub;
  assign bus.out_bad_mode  = s2_bad;

endmodule

// File: tb/tb_ieee_multi_to_fpir_pipe.sv
// tb/tb_ieee_multi_to_fpir_pipe.sv - scoreboard bench for ieee_multi_to_fpir_pipe
module tb_ieee_multi_to_fpir_pipe;

  localparam logic [2:0] T_NORMAL = 3'd0;
  localparam logic [2:0] T_PZERO  = 3'd1;
  localparam logic [2:0] T_MZERO  = 3'd2;
  localparam logic [2:0] T_PINF   = 3'd3;
  localparam logic [2:0] T_MINF   = 3'd4;
  localparam logic [2:0] T_NAN    = 3'd5;

  typedef struct {
    logic [40:0] fpir;
    logic        sub;
    logic        bad;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rstp;
  logic clear;
  always #5 clk = ~clk;

  ieee_multi_to_fpir_pipe_if bus ();

  ieee_multi_to_fpir_pipe dut (
    .clk   (clk),
    .rstp  (rstp),
    .clear (clear),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_out = 0;
  int   n_flushed = 0;
  bit   done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [40:0] pk(input logic [2:0] t, input logic s, input logic [7:0] e8,
                                     input logic [23:0] sig, input logic [1:0] ov);
    return {t, s, e8, sig, 3'b000, ov};
  endfunction

  // Value-level reference: normalise by repeated doubling, exponent as a plain integer.
  function automatic exp_t model(input logic [1:0] m, input logic [31:0] v);
    exp_t        r;
    int          mw, bias, ex;
    logic [31:0] e, man, emax, sig;
    logic        s;
    logic [2:0]  t;
    logic [9:0]  e10;
    logic [23:0] s24;
    r.sub = 0; r.bad = 0; r.acc = 0; r.lat = 0;
    case (m)
      2'd1:    begin s = v[15]; e = (v >> 10) & 32'h1F; man = v & 32'h3FF;    mw = 10; bias = 15;  emax = 31;  end
      2'd2:    begin s = v[15]; e = (v >> 7)  & 32'hFF; man = v & 32'h7F;     mw = 7;  bias = 127; emax = 255; end
      default: begin s = v[31]; e = (v >> 23) & 32'hFF; man = v & 32'h7FFFFF; mw = 23; bias = 127; emax = 255; end
    endcase
    if (m == 2'd3) begin
      r.bad  = 1;
      r.fpir = {T_NAN, s, 37'b0};
    end else if (e == emax) begin
      t = (man != 0) ? T_NAN : (s ? T_MINF : T_PINF);
      r.fpir = {t, s, 37'b0};
    end else if (e == 0 && man == 0) begin
      t = s ? T_MZERO : T_PZERO;
      r.fpir = {t, s, 37'b0};
    end else begin
      if (e == 0) begin
        r.sub = 1;
        ex = 1 - bias;
        sig = man;
        while (sig < (32'd1 << mw)) begin
          sig = sig << 1;
          ex--;
        end
      end else begin
        ex = int'(e) - bias;
        sig = man | (32'd1 << mw);
      end
      sig = sig << (23 - mw);
      s24 = sig[23:0];
      e10 = 10'(ex);
      r.fpir = {T_NORMAL, s, e10[7:0], s24, 3'b000, e10[9:8]};
    end
    return r;
  endfunction

  task automatic send(input logic [1:0] m, input logic [31:0] v, input bit lat,
                      input bit has_ref, input logic [40:0] rf, input logic rs, input logic rb);
    exp_t e;
    bit   ok;
    ok = 0;
    e = model(m, v);
    if (has_ref) begin e.fpir = rf; e.sub = rs; e.bad = rb; end
    e.lat = lat;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_value = v;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.acc = cyc;
        sb.push_back(e);
        n_acc++;
        ok = 1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got no acceptance in 100 cycles, required acceptance");
    end
  endtask

  task automatic flush_sb();
    n_flushed += sb.size();
    sb.delete();
  endtask

  task automatic drain(input string name);
    bit empty;
    empty = 0;
    for (int k = 0; k < 200 && !empty; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) empty = 1;
    end
    chk(name, 64'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    if (!rstp && bus.out_valid) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_output: got 0x%0h, required no output", bus.out_fpir);
      end else begin
        chk("out_fpir", 64'(bus.out_fpir), 64'(sb[0].fpir));
        chk("out_subnormal", 64'(bus.out_subnormal), 64'(sb[0].sub));
        chk("out_bad_mode", 64'(bus.out_bad_mode), 64'(sb[0].bad));
        if (bus.out_ready) begin
          if (sb[0].lat) chk("latency", 64'(cyc - sb[0].acc), 2);
          void'(sb.pop_front());
          n_out++;
        end
      end
    end
  end

  function automatic logic [31:0] rand_value(input logic [1:0] m);
    logic [31:0] v, mask;
    int k;
    v = $urandom;
    k = $urandom_range(0, 5);
    case (m)
      2'd1:    mask = 32'h0000_7C00;
      2'd2:    mask = 32'h0000_7F80;
      default: mask = 32'h7F80_0000;
    endcase
    case (k)
      1, 4: v = v & ~mask;
      2:    v = v | mask;
      3:    v = (m == 2'd1 || m == 2'd2) ? (v & 32'hFFFF_8000) : (v & 32'h8000_0000);
      5:    v = (m == 2'd1) ? ((v | mask) & 32'hFFFF_FC00) :
                (m == 2'd2) ? ((v | mask) & 32'hFFFF_FF80) : ((v | mask) & 32'hFF80_0000);
      default: ;
    endcase
    if (k == 4) v = v & ((m == 2'd0) ? 32'h8000_000F : 32'hFFFF_8003);
    return v;
  endfunction

  initial begin
    int   base;
    bit   seen;
    logic [1:0] m;

    rstp = 1'b1; clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_mode = 2'd0; bus.in_value = 32'd0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 0);
    chk("reset_out_fpir", 64'(bus.out_fpir), 0);
    chk("reset_out_subnormal", 64'(bus.out_subnormal), 0);
    chk("reset_out_bad_mode", 64'(bus.out_bad_mode), 0);
    chk("reset_in_ready", 64'(bus.in_ready), 1);
    @(negedge clk) rstp = 1'b0;
    @(posedge clk); #1;

    send(2'd0, 32'h3F80_0000, 1, 1, pk(T_NORMAL, 0, 8'h00, 24'h800000, 2'b00), 0, 0);
    send(2'd1, 32'h0000_0001, 1, 1, pk(T_NORMAL, 0, 8'hE8, 24'h800000, 2'b11), 1, 0);
    send(2'd0, 32'h0000_0001, 1, 1, pk(T_NORMAL, 0, 8'h6B, 24'h800000, 2'b11), 1, 0);
    send(2'd2, 32'h0000_FF80, 1, 1, pk(T_MINF, 1, 8'h00, 24'h000000, 2'b00), 0, 0);
    send(2'd1, 32'h0000_7E00, 1, 1, pk(T_NAN, 0, 8'h00, 24'h000000, 2'b00), 0, 0);
    send(2'd0, 32'h8000_0000, 1, 1, pk(T_MZERO, 1, 8'h00, 24'h000000, 2'b00), 0, 0);
    send(2'd3, 32'h0000_0000, 1, 1, pk(T_NAN, 0, 8'h00, 24'h000000, 2'b00), 0, 1);
    send(2'd1, 32'h0000_7BFF, 1, 1, pk(T_NORMAL, 0, 8'h0F, 24'hFFE000, 2'b00), 0, 0);
    send(2'd2, 32'h0000_8001, 1, 1, pk(T_NORMAL, 1, 8'h7B, 24'h800000, 2'b11), 1, 0);
    send(2'd0, 32'h7F7F_FFFF, 1, 1, pk(T_NORMAL, 0, 8'h7F, 24'hFFFFFF, 2'b00), 0, 0);
    drain("directed_drain");

    base = n_acc;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          m = 2'(i % 3);
          send(m, rand_value(m), 0, 0, '0, 0, 0);
        end
      end
      begin
        seen = 0;
        for (int k = 0; k < 50 && n_acc < base + 2; k++) @(negedge clk);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
          @(negedge clk);
          if (!bus.in_ready) seen = 1;
        end
        chk("bp_in_ready_fell", 64'(seen), 1);
        chk("bp_buffered", 64'(sb.size()), 2);
        repeat (2) begin
          @(negedge clk);
          chk("bp_in_ready_low", 64'(bus.in_ready), 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_all_accepted", 64'(n_acc - base), 6);

    bus.out_ready = 1'b0;
    send(2'd0, 32'h4049_0FDB, 0, 0, '0, 0, 0);
    send(2'd1, 32'h0000_3555, 0, 0, '0, 0, 0);
    clear = 1'b1; bus.in_valid = 1'b1; bus.in_mode = 2'd2; bus.in_value = 32'h0000_3F80;
    @(posedge clk); #1;
    clear = 1'b0; bus.in_valid = 1'b0;
    flush_sb();
    @(negedge clk);
    chk("clear_out_valid", 64'(bus.out_valid), 0);
    chk("clear_in_ready", 64'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(2'd2, 32'h0000_C0A0, 1, 0, '0, 0, 0);
    drain("clear_next_drain");

    send(2'd0, 32'h3F00_0000, 0, 0, '0, 0, 0);
    clear = 1'b1; bus.in_valid = 1'b1; bus.in_mode = 2'd0; bus.in_value = 32'h4000_0000;
    @(negedge clk);
    chk("clear_simul_in_ready", 64'(bus.in_ready), 1);
    @(posedge clk); #1;
    clear = 1'b0; bus.in_valid = 1'b0;
    flush_sb();
    repeat (4) @(posedge clk);
    #1;
    chk("clear_simul_out_valid", 64'(bus.out_valid), 0);

    bus.out_ready = 1'b0;
    send(2'd1, 32'h0000_0003, 0, 0, '0, 0, 0);
    @(posedge clk); #3;
    chk("pre_reset_out_valid", 64'(bus.out_valid), 1);
    rstp = 1'b1;
    #1;
    chk("async_reset_out_valid", 64'(bus.out_valid), 0);
    chk("async_reset_out_fpir", 64'(bus.out_fpir), 0);
    chk("async_reset_out_subnormal", 64'(bus.out_subnormal), 0);
    chk("async_reset_out_bad_mode", 64'(bus.out_bad_mode), 0);
    flush_sb();
    @(negedge clk) rstp = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          m = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          send(m, rand_value(m), 0, 0, '0, 0, 0);
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain("random_drain");
    chk("output_count", 64'(n_out), 64'(n_acc - n_flushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
